// File: rtl/spmv_mem_pkg.sv
// Shared definitions for the SpMV PE memory request arbiter:
// requester encoding, response-tag layout and the default store stride.
package spmv_mem_pkg;

   // Load tag layout on req_mem_d_or_tag: bit 0 marks an x-cache load,
   // bits [2:1] carry the decoder stream id for matrix loads.
   localparam int unsigned TAG_X_BIT   = 0;
   localparam int unsigned TAG_M_LSB   = 1;
   localparam int unsigned TAG_M_WIDTH = 2;
   localparam int unsigned TAG_WIDTH   = TAG_M_LSB + TAG_M_WIDTH;

   // Default byte increment between consecutive result stores.
   localparam int unsigned DEF_ADDR_STEP = 8;

   // Which requester owns the memory port this cycle.
   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_ST   = 2'd1,
      REQ_X    = 2'd2,
      REQ_M    = 2'd3
   } req_e;

   // Build the response-routing tag for a load request.
   function automatic logic [TAG_WIDTH-1:0] tag_bits(input logic            is_x,
                                                     input logic [TAG_M_WIDTH-1:0] mtag);
      logic [TAG_WIDTH-1:0] t;
      t = '0;
      if (is_x)
         t[TAG_X_BIT] = 1'b1;
      else
         t[TAG_M_LSB +: TAG_M_WIDTH] = mtag;
      return t;
   endfunction

endpackage

// File: rtl/spmv_mem_arbiter_starve_prio.sv
// Three-way fixed-priority selector (store > x-load > matrix-load) with
// starvation counters that promote a bypassed load requester above all others.
module spmv_starve_prio
   import spmv_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 16
)(
   input  logic clk,
   input  logic rst,
   input  logic eligible,
   input  logic st_req,
   input  logic x_valid,
   input  logic m_valid,
   output req_e grant
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] cnt_x;
   logic [CW-1:0] cnt_m;
   logic          x_forced;
   logic          m_forced;

   assign x_forced = x_valid && (cnt_x == LIMIT);
   assign m_forced = m_valid && (cnt_m == LIMIT);

   // Grant selection: a starved load wins first (x before m), then base priority.
   always_comb begin
      grant = REQ_NONE;
      if (eligible) begin
         if (x_forced)
            grant = REQ_X;
         else if (m_forced)
            grant = REQ_M;
         else if (st_req)
            grant = REQ_ST;
         else if (x_valid)
            grant = REQ_X;
         else if (m_valid)
            grant = REQ_M;
      end
   end

   // Starvation counters: count eligible cycles a pending load is bypassed,
   // saturating at the limit; cleared on grant or when the request goes away.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_x <= '0;
         cnt_m <= '0;
      end else begin
         if (!x_valid || grant == REQ_X)
            cnt_x <= '0;
         else if (eligible && cnt_x != LIMIT)
            cnt_x <= cnt_x + CW'(1);

         if (!m_valid || grant == REQ_M)
            cnt_m <= '0;
         else if (eligible && cnt_m != LIMIT)
            cnt_m <= cnt_m + CW'(1);
      end
   end

endmodule

// File: rtl/spmv_mem_arbiter.sv
// Memory request arbiter for one SpMV PE: schedules the single request port
// among result stores, x-cache loads and matrix-decoder loads, owns the
// result-store address window and registers the outgoing request.
module spmv_mem_arbiter
   import spmv_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 48,
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned STARVE_LIMIT = 16,
   parameter int unsigned ADDR_STEP    = DEF_ADDR_STEP
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  st_valid,
   input  logic [DATA_WIDTH-1:0] st_data,
   output logic                  st_ready,
   input  logic                  ldx_valid,
   input  logic [ADDR_WIDTH-1:0] ldx_addr,
   output logic                  ldx_ready,
   input  logic                  ldm_valid,
   input  logic [ADDR_WIDTH-1:0] ldm_addr,
   input  logic [1:0]            ldm_tag,
   output logic                  ldm_ready,
   input  logic                  st_base_load,
   input  logic [ADDR_WIDTH-1:0] st_base,
   input  logic [ADDR_WIDTH-1:0] st_end,
   output logic                  st_done,
   output logic                  st_dropped,
   output logic                  req_mem_ld,
   output logic                  req_mem_st,
   output logic [ADDR_WIDTH-1:0] req_mem_addr,
   output logic [DATA_WIDTH-1:0] req_mem_d_or_tag,
   input  logic                  req_mem_stall
);

   logic                  eligible;
   logic                  st_req;
   req_e                  grant;
   logic [ADDR_WIDTH-1:0] st_addr;
   logic [ADDR_WIDTH-1:0] st_end_r;

   // Stall is sampled here; a request already registered still goes out.
   assign eligible = enable && !req_mem_stall && !rst;
   // A window reload blocks the store for one cycle so it issues at the new base.
   assign st_req   = st_valid && !st_base_load;

   spmv_starve_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk      (clk),
      .rst      (rst),
      .eligible (eligible),
      .st_req   (st_req),
      .x_valid  (ldx_valid),
      .m_valid  (ldm_valid),
      .grant    (grant)
   );

   assign st_ready  = (grant == REQ_ST);
   assign ldx_ready = (grant == REQ_X);
   assign ldm_ready = (grant == REQ_M);
   assign st_done   = (st_addr == st_end_r);

   // Store address window: reload, advance per issued store, flag discards.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_addr    <= '0;
         st_end_r   <= '0;
         st_dropped <= 1'b0;
      end else if (st_base_load) begin
         st_addr    <= st_base;
         st_end_r   <= st_end;
         st_dropped <= 1'b0;
      end else if (grant == REQ_ST) begin
         if (st_done)
            st_dropped <= 1'b1;
         else
            st_addr <= st_addr + ADDR_WIDTH'(ADDR_STEP);
      end
   end

   // Request register: one cycle after grant; address/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_mem_ld       <= 1'b0;
         req_mem_st       <= 1'b0;
         req_mem_addr     <= '0;
         req_mem_d_or_tag <= '0;
      end else begin
         req_mem_st <= (grant == REQ_ST) && !st_done;
         req_mem_ld <= (grant == REQ_X) || (grant == REQ_M);
         case (grant)
            REQ_ST: begin
               if (!st_done) begin
                  req_mem_addr     <= st_addr;
                  req_mem_d_or_tag <= st_data;
               end
            end
            REQ_X: begin
               req_mem_addr     <= ldx_addr;
               req_mem_d_or_tag <= DATA_WIDTH'(tag_bits(1'b1, 2'b00));
            end
            REQ_M: begin
               req_mem_addr     <= ldm_addr;
               req_mem_d_or_tag <= DATA_WIDTH'(tag_bits(1'b0, ldm_tag));
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed self-checking bench for spmv_mem_arbiter with a request scoreboard.
module tb_spmv_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        st_valid;
   logic [63:0] st_data;
   logic        st_ready;
   logic        ldx_valid;
   logic [47:0] ldx_addr;
   logic        ldx_ready;
   logic        ldm_valid;
   logic [47:0] ldm_addr;
   logic [1:0]  ldm_tag;
   logic        ldm_ready;
   logic        st_base_load;
   logic [47:0] st_base;
   logic [47:0] st_end;
   logic        st_done;
   logic        st_dropped;
   logic        req_mem_ld;
   logic        req_mem_st;
   logic [47:0] req_mem_addr;
   logic [63:0] req_mem_d_or_tag;
   logic        req_mem_stall;

   spmv_mem_arbiter #(
      .ADDR_WIDTH   (48),
      .DATA_WIDTH   (64),
      .STARVE_LIMIT (4),
      .ADDR_STEP    (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .st_valid         (st_valid),
      .st_data          (st_data),
      .st_ready         (st_ready),
      .ldx_valid        (ldx_valid),
      .ldx_addr         (ldx_addr),
      .ldx_ready        (ldx_ready),
      .ldm_valid        (ldm_valid),
      .ldm_addr         (ldm_addr),
      .ldm_tag          (ldm_tag),
      .ldm_ready        (ldm_ready),
      .st_base_load     (st_base_load),
      .st_base          (st_base),
      .st_end           (st_end),
      .st_done          (st_done),
      .st_dropped       (st_dropped),
      .req_mem_ld       (req_mem_ld),
      .req_mem_st       (req_mem_st),
      .req_mem_addr     (req_mem_addr),
      .req_mem_d_or_tag (req_mem_d_or_tag),
      .req_mem_stall    (req_mem_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        ld;
      logic        st;
      logic [47:0] addr;
      logic [63:0] d;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic exp_t e_none();
      exp_t e;
      e = '0;
      return e;
   endfunction

   function automatic exp_t e_st(input logic [47:0] a, input logic [63:0] d);
      exp_t e;
      e.ld = 1'b0; e.st = 1'b1; e.addr = a; e.d = d;
      return e;
   endfunction

   function automatic exp_t e_x(input logic [47:0] a);
      exp_t e;
      e.ld = 1'b1; e.st = 1'b0; e.addr = a; e.d = 64'h1;
      return e;
   endfunction

   function automatic exp_t e_m(input logic [47:0] a, input logic [1:0] t);
      exp_t e;
      e.ld = 1'b1; e.st = 1'b0; e.addr = a; e.d = {61'b0, t, 1'b0};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: readies checked mid-cycle, expected request pushed, then the
   // registered request popped and compared just after the next rising edge.
   task automatic cyc(input string tag, input logic [2:0] exp_rdy, input exp_t e);
      exp_t got;
      @(negedge clk);
      chk({tag, "/ready"}, 64'({st_ready, ldx_ready, ldm_ready}), 64'(exp_rdy));
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s/scoreboard: observed empty, expected one entry", tag);
      end else begin
         got = sb.pop_front();
         chk({tag, "/ld"}, 64'(req_mem_ld), 64'(got.ld));
         chk({tag, "/st"}, 64'(req_mem_st), 64'(got.st));
         if (got.ld || got.st) begin
            chk({tag, "/addr"}, 64'(req_mem_addr), 64'(got.addr));
            chk({tag, "/data"}, req_mem_d_or_tag, got.d);
         end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; req_mem_stall = 1'b0;
      st_valid = 1'b0; st_data = '0;
      ldx_valid = 1'b0; ldx_addr = '0;
      ldm_valid = 1'b0; ldm_addr = '0; ldm_tag = '0;
      st_base_load = 1'b0; st_base = '0; st_end = '0;

      // Reset state
      cyc("reset0", 3'b000, e_none());
      chk("reset/st_done", 64'(st_done), 64'h1);
      chk("reset/st_dropped", 64'(st_dropped), 64'h0);
      chk("reset/addr", 64'(req_mem_addr), 64'h0);
      chk("reset/data", req_mem_d_or_tag, 64'h0);
      st_valid = 1'b1; ldx_valid = 1'b1; ldm_valid = 1'b1;
      cyc("reset1", 3'b000, e_none());

      // Load window 0x1000..0x1018
      rst = 1'b0; enable = 1'b1;
      st_valid = 1'b0; ldx_valid = 1'b0; ldm_valid = 1'b0;
      st_base_load = 1'b1; st_base = 48'h1000; st_end = 48'h1018;
      cyc("win1", 3'b000, e_none());
      chk("win1/st_done", 64'(st_done), 64'h0);

      // Three back-to-back stores
      st_base_load = 1'b0; st_valid = 1'b1;
      st_data = 64'hD0;
      cyc("st0", 3'b100, e_st(48'h1000, 64'hD0));
      st_data = 64'hD1;
      cyc("st1", 3'b100, e_st(48'h1008, 64'hD1));
      chk("st1/st_done", 64'(st_done), 64'h0);
      st_data = 64'hD2;
      cyc("st2", 3'b100, e_st(48'h1010, 64'hD2));
      chk("st2/st_done", 64'(st_done), 64'h1);

      // Store beyond window: popped and discarded
      st_data = 64'hD3;
      cyc("drop", 3'b100, e_none());
      chk("drop/st_dropped", 64'(st_dropped), 64'h1);

      // Reload clears the sticky drop flag
      st_valid = 1'b0; st_base_load = 1'b1; st_base = 48'h2000; st_end = 48'h2040;
      cyc("win2", 3'b000, e_none());
      chk("win2/st_dropped", 64'(st_dropped), 64'h0);
      chk("win2/st_done", 64'(st_done), 64'h0);

      // Reload concurrent with a pending store: x-load goes instead
      st_base = 48'h3000; st_end = 48'h3100;
      st_valid = 1'b1; st_data = 64'hE0;
      ldx_valid = 1'b1; ldx_addr = 48'hABC0;
      cyc("bl_x", 3'b010, e_x(48'hABC0));
      st_base_load = 1'b0; ldx_valid = 1'b0;
      cyc("bl_st", 3'b100, e_st(48'h3000, 64'hE0));

      // Starvation with all three valid, limit 4
      ldx_valid = 1'b1; ldx_addr = 48'h4440;
      ldm_valid = 1'b1; ldm_addr = 48'h5550; ldm_tag = 2'b10;
      for (int i = 0; i < 4; i++) begin
         st_data = 64'h1111 * 64'(i + 1);
         cyc("starve_st", 3'b100, e_st(48'h3008 + 48'(8 * i), 64'h1111 * 64'(i + 1)));
      end
      cyc("starve_x", 3'b010, e_x(48'h4440));
      cyc("starve_m", 3'b001, e_m(48'h5550, 2'b10));
      st_data = 64'hF0;
      cyc("after_m", 3'b100, e_st(48'h3028, 64'hF0));

      // Stall for five cycles with all valid
      req_mem_stall = 1'b1;
      for (int i = 0; i < 5; i++)
         cyc("stall", 3'b000, e_none());
      req_mem_stall = 1'b0; st_data = 64'hF1;
      cyc("unstall", 3'b100, e_st(48'h3030, 64'hF1));

      // enable low: no grants
      enable = 1'b0;
      cyc("disabled", 3'b000, e_none());
      enable = 1'b1; st_data = 64'hF2;
      cyc("reenable", 3'b100, e_st(48'h3038, 64'hF2));

      // Reset mid-stream
      rst = 1'b1;
      cyc("rst_mid0", 3'b000, e_none());
      chk("rst_mid/st_done", 64'(st_done), 64'h1);
      chk("rst_mid/st_dropped", 64'(st_dropped), 64'h0);
      cyc("rst_mid1", 3'b000, e_none());
      rst = 1'b0; st_valid = 1'b0; ldm_valid = 1'b0;
      cyc("post_rst_x", 3'b010, e_x(48'h4440));
      // Empty window after reset: store discarded
      ldx_valid = 1'b0; st_valid = 1'b1;
      cyc("post_rst_drop", 3'b100, e_none());
      chk("post_rst/st_dropped", 64'(st_dropped), 64'h1);

      // Address wrap at the top of the address space
      st_valid = 1'b0; st_base_load = 1'b1;
      st_base = 48'hFFFF_FFFF_FFF8; st_end = 48'h8;
      cyc("wrap_win", 3'b000, e_none());
      chk("wrap_win/st_dropped", 64'(st_dropped), 64'h0);
      st_base_load = 1'b0; st_valid = 1'b1; st_data = 64'hAA;
      cyc("wrap_st0", 3'b100, e_st(48'hFFFF_FFFF_FFF8, 64'hAA));
      st_data = 64'hBB;
      cyc("wrap_st1", 3'b100, e_st(48'h0, 64'hBB));
      chk("wrap/st_done", 64'(st_done), 64'h1);
      st_valid = 1'b0;
      cyc("idle", 3'b000, e_none());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
